btn_conditioner: RTL and testbench



---
 rtl/btn_conditioner.sv | 133 +++++++++++++
 tb/tb_btn_conditioner.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/btn_conditioner.sv
// Conditions four raw active-low direction buttons into active-low single-cycle move
// strobes: two-flop synchroniser, debounce, press/hold-to-repeat FSM, opposite-direction veto.
module btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 25000000,
    parameter int REPEAT_EN       = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up_n,
    input  logic       btn_down_n,
    input  logic       btn_left_n,
    input  logic       btn_right_n,
    output logic       up,
    output logic       down,
    output logic       left,
    output logic       right,
    output logic [3:0] held
);

    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RW   = $clog2(RMAX + 1);

    localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);
    localparam logic [RW-1:0] RPT_SAT     = RW'(RMAX);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HOLD = 2'd1;
    localparam logic [1:0] S_RPT  = 2'd2;

    // Channel order everywhere: [3]=up, [2]=down, [1]=left, [0]=right
    logic [3:0]    raw;
    logic [3:0]    sync_p0;
    logic [3:0]    sync_p1;
    logic [3:0]    stable;
    logic [3:0]    fire;
    logic [3:0]    emit;
    logic [DW-1:0] db_cnt    [4];
    logic [1:0]    state     [4];
    logic [1:0]    state_nxt [4];
    logic [RW-1:0] rpt_cnt   [4];
    logic [RW-1:0] rpt_nxt   [4];

    assign raw  = {btn_up_n, btn_down_n, btn_left_n, btn_right_n};
    assign held = stable;

    // Press/repeat FSM runs off the debounced level; a release always wins over a due repeat
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            fire[i]      = 1'b0;
            state_nxt[i] = state[i];
            rpt_nxt[i]   = rpt_cnt[i];
            if (!stable[i]) begin
                state_nxt[i] = S_IDLE;
                rpt_nxt[i]   = '0;
            end else begin
                case (state[i])
                    S_IDLE: begin
                        fire[i]      = 1'b1;
                        state_nxt[i] = S_HOLD;
                        rpt_nxt[i]   = '0;
                    end
                    S_HOLD: begin
                        if (REPEAT_EN != 0 && rpt_cnt[i] == DELAY_LAST) begin
                            fire[i]      = 1'b1;
                            state_nxt[i] = S_RPT;
                            rpt_nxt[i]   = '0;
                        end else if (rpt_cnt[i] != RPT_SAT) begin
                            rpt_nxt[i] = rpt_cnt[i] + RW'(1);
                        end
                    end
                    S_RPT: begin
                        if (rpt_cnt[i] == PERIOD_LAST) begin
                            fire[i]    = 1'b1;
                            rpt_nxt[i] = '0;
                        end else if (rpt_cnt[i] != RPT_SAT) begin
                            rpt_nxt[i] = rpt_cnt[i] + RW'(1);
                        end
                    end
                    default: begin
                        state_nxt[i] = S_IDLE;
                        rpt_nxt[i]   = '0;
                    end
                endcase
            end
        end
    end

    // Opposite directions cancel each other; the FSMs themselves are unaffected
    always_comb begin
        emit = fire;
        if (fire[3] && fire[2]) emit[3:2] = 2'b00;
        if (fire[1] && fire[0]) emit[1:0] = 2'b00;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0 <= 4'hF;
            sync_p1 <= 4'hF;
            stable  <= 4'h0;
            for (int i = 0; i < 4; i++) begin
                db_cnt[i]  <= '0;
                state[i]   <= S_IDLE;
                rpt_cnt[i] <= '0;
            end
            {up, down, left, right} <= 4'hF;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
            for (int i = 0; i < 4; i++) begin
                // sync_p1 is active-low, stable is active-high: equal bits mean disagreement
                if (sync_p1[i] == stable[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        stable[i] <= ~stable[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + DW'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
                state[i]   <= state_nxt[i];
                rpt_cnt[i] <= rpt_nxt[i];
            end
            {up, down, left, right} <= ~emit;
        end
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5;
// edge e is the e-th clock edge after the scenario starts driving, outputs sampled 1ns after it.
module tb_btn_conditioner;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] raw_n = 4'hF;
    logic [3:0] raw2_n = 4'hF;
    logic       up, down, left, right;
    logic [3:0] held;
    logic       up2, down2, left2, right2;
    logic [3:0] held2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    btn_conditioner #(
        .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(5), .REPEAT_EN(1)
    ) dut (
        .clk(clk), .reset(reset),
        .btn_up_n(raw_n[3]), .btn_down_n(raw_n[2]), .btn_left_n(raw_n[1]), .btn_right_n(raw_n[0]),
        .up(up), .down(down), .left(left), .right(right), .held(held)
    );

    btn_conditioner #(
        .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(5), .REPEAT_EN(0)
    ) dut_norpt (
        .clk(clk), .reset(reset),
        .btn_up_n(raw2_n[3]), .btn_down_n(raw2_n[2]), .btn_left_n(raw2_n[1]), .btn_right_n(raw2_n[0]),
        .up(up2), .down(down2), .left(left2), .right(right2), .held(held2)
    );

    typedef struct {
        string      name;
        logic [3:0] chans;
        int         lo_edges;
        int         n_edges;
        int         n_str;
        int         str [8];
    } scen_t;

    scen_t tbl [3];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string name, input int e, input logic [3:0] got, input logic [3:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s edge %0d: got %b expected %b", name, e, got, exp);
        end
    endtask

    task automatic do_reset;
        reset  = 1'b1;
        raw_n  = 4'hF;
        raw2_n = 4'hF;
        tick();
        tick();
        cmp("reset_strobes", -1, {up, down, left, right}, 4'hF);
        cmp("reset_held", -1, held, 4'h0);
        cmp("reset_strobes_norpt", -1, {up2, down2, left2, right2}, 4'hF);
        cmp("reset_held_norpt", -1, held2, 4'h0);
        reset = 1'b0;
    endtask

    function automatic bit is_strobe(input scen_t s, input int e);
        for (int j = 0; j < s.n_str; j++)
            if (s.str[j] == e) return 1'b1;
        return 1'b0;
    endfunction

    initial begin
        logic [3:0] exp_s;
        logic [3:0] exp_h;

        tbl[0] = '{name: "clean_up", chans: 4'b1000, lo_edges: 8, n_edges: 20, n_str: 1,
                   str: '{6, 0, 0, 0, 0, 0, 0, 0}};
        tbl[1] = '{name: "repeat_right", chans: 4'b0001, lo_edges: 40, n_edges: 60, n_str: 7,
                   str: '{6, 16, 21, 26, 31, 36, 41, 0}};
        tbl[2] = '{name: "conflict_ud", chans: 4'b1100, lo_edges: 12, n_edges: 25, n_str: 0,
                   str: '{0, 0, 0, 0, 0, 0, 0, 0}};

        // Continuous presses: held spans edges [5, release+5), strobes only at listed edges
        for (int k = 0; k < 3; k++) begin
            do_reset();
            for (int e = 0; e < tbl[k].n_edges; e++) begin
                raw_n = (e < tbl[k].lo_edges) ? ~tbl[k].chans : 4'hF;
                tick();
                exp_s = is_strobe(tbl[k], e) ? ~tbl[k].chans : 4'hF;
                exp_h = (e >= 5 && e < tbl[k].lo_edges + 5) ? tbl[k].chans : 4'h0;
                cmp({tbl[k].name, "_strobe"}, e, {up, down, left, right}, exp_s);
                cmp({tbl[k].name, "_held"}, e, held, exp_h);
            end
        end

        // Bounce on left: low 3, high 2, low 3, then high -- never reaches 4 consecutive
        do_reset();
        for (int e = 0; e < 20; e++) begin
            raw_n = 4'hF;
            raw_n[1] = !((e < 3) || (e >= 5 && e < 8));
            tick();
            cmp("bounce_strobe", e, {up, down, left, right}, 4'hF);
            cmp("bounce_held", e, held, 4'h0);
        end

        // Reset on edge 18 while down is held; re-press seen from edge 19, strobe at 25
        do_reset();
        for (int e = 0; e < 33; e++) begin
            raw_n = 4'b1011;
            reset = (e == 18);
            tick();
            exp_s = (e == 6 || e == 16 || e == 25) ? 4'b1011 : 4'hF;
            exp_h = ((e >= 5 && e < 18) || e >= 24) ? 4'b0100 : 4'h0;
            cmp("rst_mid_strobe", e, {up, down, left, right}, exp_s);
            cmp("rst_mid_held", e, held, exp_h);
        end
        reset = 1'b0;

        // Auto-repeat disabled: one strobe per press
        do_reset();
        for (int e = 0; e < 60; e++) begin
            raw2_n = (e < 40) ? 4'b0111 : 4'hF;
            tick();
            exp_s = (e == 6) ? 4'b0111 : 4'hF;
            exp_h = (e >= 5 && e < 45) ? 4'b1000 : 4'h0;
            cmp("norpt_strobe", e, {up2, down2, left2, right2}, exp_s);
            cmp("norpt_held", e, held2, exp_h);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
